// File: rtl/icache.sv
// Direct-mapped instruction cache with combinational hit path.
// A miss stalls the fetch stage while the whole line is refilled word by
// word from memory (one outstanding request); lookup resumes afterwards
// on whatever address ifetch is presenting at that time.
//
// Memory handshake: while mem_req_o is high, mem_adr_o is held stable; a
// cycle with mem_ack_i high completes that request and mem_rdata_i is
// captured at the same rising edge. mem_ack_i is ignored outside REFILL.
//
// The line geometry assumes LINE_WORDS >= 2 and NB_LINES >= 2.
module icache #(
    parameter int XLEN       = 32,
    parameter int NB_LINES   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] icache_adr_i,
    output logic [31:0]     icache_instr_o,
    output logic            icache_stall_o,
    input  logic            inv_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    input  logic            mem_ack_i,
    input  logic [31:0]     mem_rdata_i,
    output logic            o_dbg_state
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int LB = $clog2(NB_LINES);
    localparam int TB = XLEN - 2 - WB - LB;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Address split of the current fetch address.
    logic [TB-1:0] w_tag;
    logic [LB-1:0] w_idx;
    logic [WB-1:0] w_word;
    logic [1:0]    w_unused_byte_ofs;

    assign w_word            = icache_adr_i[2+WB-1:2];
    assign w_idx             = icache_adr_i[2+WB+LB-1:2+WB];
    assign w_tag             = icache_adr_i[XLEN-1:2+WB+LB];
    assign w_unused_byte_ofs = icache_adr_i[1:0];

    // Storage: valid bits are reset, tag/data arrays are not.
    logic [NB_LINES-1:0] r_valid;
    logic [TB-1:0]       r_tag_arr  [NB_LINES];
    logic [31:0]         r_data_arr [NB_LINES*LINE_WORDS];

    // Refill context latched at the miss.
    logic [TB-1:0] r_ref_tag;
    logic [LB-1:0] r_ref_idx;
    logic [WB-1:0] r_cnt;
    logic          r_inv_pend;

    logic w_hit;
    logic w_start;
    logic w_ack;
    logic w_last;

    assign w_hit   = reset_n && (r_state == S_IDLE) && r_valid[w_idx]
                     && (r_tag_arr[w_idx] == w_tag);
    // inv_i on a miss suppresses the refill for that cycle.
    assign w_start = (r_state == S_IDLE) && !w_hit && !inv_i;
    assign w_ack   = (r_state == S_REFILL) && mem_ack_i;
    assign w_last  = w_ack && (r_cnt == LAST_WORD);

    // Fetch-side outputs: zero-latency hit, NOP + stall otherwise, quiet in reset.
    assign icache_instr_o = w_hit ? r_data_arr[{w_idx, w_word}] : NOP;
    assign icache_stall_o = reset_n && !w_hit;
    assign o_dbg_state    = r_state;

    // Next-state and memory request generation.
    always_comb begin
        w_state_nxt = r_state;
        mem_req_o   = 1'b0;
        mem_adr_o   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_REFILL;
            end
            S_REFILL: begin
                mem_req_o = 1'b1;
                mem_adr_o = {r_ref_tag, r_ref_idx, r_cnt, 2'b00};
                if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Refill context: latch line address at the miss, step the word counter on each ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ref_tag <= '0;
            r_ref_idx <= '0;
            r_cnt     <= '0;
        end else if (w_start) begin
            r_ref_tag <= w_tag;
            r_ref_idx <= w_idx;
            r_cnt     <= '0;
        end else if (w_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Remember an invalidate seen during a refill so the refilled line stays invalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                              r_inv_pend <= 1'b0;
        else if (w_start || w_last)                r_inv_pend <= 1'b0;
        else if ((r_state == S_REFILL) && inv_i)   r_inv_pend <= 1'b1;
    end

    // Valid bits: global clear on invalidate, line cleared while being overwritten, set on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (inv_i) begin
            r_valid <= '0;
        end else if (w_start) begin
            r_valid[w_idx] <= 1'b0;
        end else if (w_last && !r_inv_pend) begin
            r_valid[r_ref_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are written by the refill only.
    always_ff @(posedge clk) begin
        if (w_ack)  r_data_arr[{r_ref_idx, r_cnt}] <= mem_rdata_i;
        if (w_last) r_tag_arr[r_ref_idx]           <= r_ref_tag;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width.
REQ-002 SHALL have parameter NB_LINES, default 16, number of direct-mapped lines (power of 2).
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2).
REQ-004 SHALL have port clk  input  1  clock, all flops on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port icache_adr_i  input  XLEN  fetch address from ifetch, sampled every cycle.
REQ-007 SHALL have port icache_instr_o  output  32  instruction for icache_adr_i, same cycle (combinational read).
REQ-008 SHALL have port icache_stall_o  output  1  high when icache_instr_o is not valid for icache_adr_i.
REQ-009 SHALL have port inv_i  input  1  invalidate all lines (fence.i).
REQ-010 SHALL have port mem_req_o  output  1  word read request to memory.
REQ-011 SHALL have port mem_adr_o  output  XLEN  word-aligned memory read address.
REQ-012 SHALL have port mem_ack_i  input  1  memory returns mem_rdata_i this cycle.
REQ-013 SHALL have port mem_rdata_i  input  32  memory read data.

Function
REQ-014 SHALL split icache_adr_i into byte offset [1:0] (ignored), word index log2(LINE_WORDS) bits, line index log2(NB_LINES) bits, and tag (remaining upper bits).
REQ-015 SHALL declare a hit when the FSM is IDLE, the indexed line is valid, its stored tag equals the address tag, and reset_n is high.
REQ-016 SHALL, on hit, drive icache_instr_o with the stored word and icache_stall_o=0 in the same cycle, with zero latency.
REQ-017 SHALL, on any non-hit cycle, drive icache_instr_o=32'h0000_0013 (NOP) and icache_stall_o=1.
REQ-018 SHALL implement the FSM states IDLE and REFILL.
REQ-019 SHALL transition IDLE->REFILL on a miss while inv_i=0, latching the line address (tag and index) and clearing the word counter.
REQ-020 SHALL, in REFILL, assert mem_req_o with mem_adr_o={latched tag, latched index, word counter, 2'b00}, fetching words in order 0..LINE_WORDS-1.
REQ-021 SHALL hold mem_req_o and mem_adr_o stable until mem_ack_i; on ack, it SHALL write mem_rdata_i to the line's data slot and increment the counter, with only one request outstanding.
REQ-022 SHALL, on the ack of word LINE_WORDS-1, write the latched tag, set the line valid, and return to IDLE; the next cycle SHALL hit if the address is unchanged (miss penalty = sum of ack latencies + 1 cycle).
REQ-023 SHALL ignore changes of icache_adr_i during REFILL (branch flush): the refill completes for the latched line, then lookup resumes on the current address.
REQ-024 SHALL, on inv_i=1, clear all valid bits at the next edge; during REFILL it SHALL complete the refill but leave the refilled line invalid; inv_i in IDLE on a miss SHALL NOT start a refill that cycle.
REQ-025 SHALL ignore mem_ack_i while in IDLE.
REQ-026 SHALL keep mem_req_o=0 in IDLE.

Reset
REQ-027 SHALL, with reset_n low, asynchronously clear all valid bits and set the FSM to IDLE, the counter to 0, mem_req_o=0, mem_adr_o=0, icache_stall_o=0 and icache_instr_o=32'h0000_0013.
REQ-028 SHALL NOT need to reset the tag and data arrays.
REQ-029 SHALL, on reset assertion mid-REFILL, abandon the refill and leave the line invalid.

Verification
REQ-030 SHALL be verified by a cold miss: reset, adr=0x80, ack 1 cycle after each req -> stall=1, mem_adr 0x80,0x84,0x88,0x8C, then hit with instr=mem word at 0x80 and stall=0.
REQ-031 SHALL be verified by a line hit: after REQ-030, adr=0x8C -> instr=word 0x8C, stall=0, mem_req_o=0.
REQ-032 SHALL be verified by a conflict miss: adr=0x80 cached, adr=0x180 (same index, different tag) -> refill 0x180..0x18C, after which 0x80 misses again.
REQ-033 SHALL be verified by a flush mid-refill: miss on 0x200, adr changed to 0x300 after 2 acks -> the 0x200 line completes and becomes valid, then 0x300 refills.
REQ-034 SHALL be verified by invalidation: inv_i pulsed in IDLE with lines valid -> all previously hitting addresses stall; inv_i during REFILL -> the line stays invalid and is re-fetched.
REQ-035 SHALL be verified by reset mid-refill: reset_n low after 1 ack -> mem_req_o=0 immediately; after release, the same address misses and refills from word 0.
